// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: CH register-file write channels with valid/ready flow control,
// flush, write-enable sanitising and a retire counter. Define MEM_WB_SKID_EN for the two-entry skid build.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CH     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] ans_i,
    input  logic [CH-1:0]        write_enable_i,
    input  logic [CH*ADDR_W-1:0] write_addr_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] ans_o,
    output logic [CH-1:0]        write_enable_o,
    output logic [CH*ADDR_W-1:0] write_addr_o,
    output logic [31:0]          retire_cnt
);

    // Drop writes to $zero and writes shadowed by a higher channel to the same register.
    function automatic logic [CH-1:0] sanitize_we(input logic [CH-1:0]        we,
                                                 input logic [CH*ADDR_W-1:0] addr);
        logic [CH-1:0] res;
        res = {CH{1'b0}};
        for (int k = 0; k < CH; k++) begin
            res[k] = we[k] && (addr[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}});
            for (int j = k + 1; j < CH; j++) begin
                if (we[j] && (addr[j*ADDR_W +: ADDR_W] == addr[k*ADDR_W +: ADDR_W])) begin
                    res[k] = 1'b0;
                end
            end
        end
        return res;
    endfunction

    logic                 valid_q, valid_d;
    logic [CH*DATA_W-1:0] ans_q, ans_d;
    logic [CH*ADDR_W-1:0] addr_q, addr_d;
    logic [CH-1:0]        we_q, we_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [CH-1:0]        load_we_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 fire_s;

    assign load_we_s = sanitize_we(write_enable_i, write_addr_i);
    assign accept_s  = in_valid & in_ready_s;
    assign fire_s    = valid_q & out_ready;

`ifdef MEM_WB_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [CH*DATA_W-1:0] skid_ans_q, skid_ans_d;
    logic [CH*ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic [CH-1:0]        skid_we_q, skid_we_d;

    assign in_ready_s = in_ready_q;

    // Skid buffer next state: main entry drives outputs, skid entry catches the beat that arrives during a stall.
    always_comb begin
        state_d     = state_q;
        ans_d       = ans_q;
        addr_d      = addr_q;
        we_d        = we_q;
        skid_ans_d  = skid_ans_q;
        skid_addr_d = skid_addr_q;
        skid_we_d   = skid_we_q;
        if (flush) begin
            state_d = S_EMPTY;
            we_d    = {CH{1'b0}};
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_s) begin
                        ans_d   = ans_i;
                        addr_d  = write_addr_i;
                        we_d    = load_we_s;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (accept_s && fire_s) begin
                        ans_d   = ans_i;
                        addr_d  = write_addr_i;
                        we_d    = load_we_s;
                    end else if (accept_s) begin
                        skid_ans_d  = ans_i;
                        skid_addr_d = write_addr_i;
                        skid_we_d   = load_we_s;
                        state_d     = S_FULL;
                    end else if (fire_s) begin
                        we_d    = {CH{1'b0}};
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_FULL: begin
                    if (fire_s) begin
                        ans_d   = skid_ans_q;
                        addr_d  = skid_addr_q;
                        we_d    = skid_we_q;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                default: begin
                    we_d    = {CH{1'b0}};
                    state_d = S_EMPTY;
                end
            endcase
        end
        valid_d    = (state_d != S_EMPTY);
        in_ready_d = (state_d != S_FULL);
    end

    // Skid state and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            skid_ans_q  <= {(CH*DATA_W){1'b0}};
            skid_addr_q <= {(CH*ADDR_W){1'b0}};
            skid_we_q   <= {CH{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            skid_ans_q  <= skid_ans_d;
            skid_addr_q <= skid_addr_d;
            skid_we_q   <= skid_we_d;
        end
    end
`else
    assign in_ready_s = ~valid_q | out_ready;

    // Single-entry next state; enables are cleared whenever the entry empties.
    always_comb begin
        valid_d = valid_q;
        ans_d   = ans_q;
        addr_d  = addr_q;
        we_d    = we_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = {CH{1'b0}};
        end else if (accept_s) begin
            valid_d = 1'b1;
            ans_d   = ans_i;
            addr_d  = write_addr_i;
            we_d    = load_we_s;
        end else if (fire_s) begin
            valid_d = 1'b0;
            we_d    = {CH{1'b0}};
        end else begin
            valid_d = valid_q;
        end
    end
`endif

    // Retire counter counts every fire, including one coinciding with flush.
    always_comb begin
        if (fire_s) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output register and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ans_q   <= {(CH*DATA_W){1'b0}};
            addr_q  <= {(CH*ADDR_W){1'b0}};
            we_q    <= {CH{1'b0}};
            cnt_q   <= 32'd0;
        end else begin
            valid_q <= valid_d;
            ans_q   <= ans_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = valid_q;
    assign ans_o          = ans_q;
    assign write_addr_o   = addr_q;
    assign write_enable_o = we_q;
    assign retire_cnt     = cnt_q;

endmodule
